fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch unit with a prefetch queue. It reads a
//               combinational instruction memory at the internal fetch PC
//               and buffers {pc, instruction} pairs for decode. It stops
//               fetching permanently after HALT_ZEROS consecutive all-zero
//               words.
// Ports       : clock, reset        - clock, async active-high reset
//               imem_addr/imem_data - instruction memory read port
//               redirect/redirect_pc - flush queue and restart fetch
//               out_valid/out_ready - head handshake to decode
//               out_inst/out_pc/out_pc4 - head entry contents
//               count               - queue occupancy
//               halt                - sticky halt flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                HALT_ZEROS = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc4,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ZC_W  = $clog2(HALT_ZEROS+1);

    localparam logic [CNT_W-1:0]  c_depth      = CNT_W'(DEPTH);
    localparam logic [ZC_W-1:0]   c_halt_zeros = ZC_W'(HALT_ZEROS);
    localparam logic [ADDR_W-1:0] c_four       = ADDR_W'(4);

    logic [ADDR_W-1:0] r_fpc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ZC_W-1:0]   r_zc;
    logic              r_halt;

    logic [31:0]       r_inst_q [DEPTH];
    logic [ADDR_W-1:0] r_pc_q   [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_zero_word;
    logic [ZC_W-1:0]   w_zc_inc;

    assign imem_addr = r_fpc;
    assign out_valid = (r_count != '0);
    assign out_inst  = r_inst_q[r_rd_ptr];
    assign out_pc    = r_pc_q[r_rd_ptr];
    assign out_pc4   = r_pc_q[r_rd_ptr] + c_four;
    assign count     = r_count;
    assign halt      = r_halt;

    // Pop is evaluated first so a full queue can accept a push into the
    // slot being freed in the same cycle.
    assign w_pop       = out_valid && out_ready && !redirect;
    assign w_push      = !r_halt && !redirect && ((r_count < c_depth) || w_pop);
    assign w_zero_word = (imem_data == 32'd0);
    assign w_zc_inc    = r_zc + ZC_W'(1);

    // Queue storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_inst_q[r_wr_ptr] <= imem_data;
            r_pc_q[r_wr_ptr]   <= r_fpc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fpc    <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_zc     <= '0;
            r_halt   <= 1'b0;
        end else if (redirect) begin
            // Halt is deliberately left untouched: a halted unit stays halted.
            r_fpc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_zc     <= '0;
        end else begin
            if (w_push) begin
                r_fpc    <= r_fpc + c_four;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_zero_word) begin
                    r_zc <= w_zc_inc;
                    if (w_zc_inc == c_halt_zeros) begin
                        r_halt <= 1'b1;
                    end
                end else begin
                    r_zc <= '0;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with default
//               parameters (ADDR_W=32, DEPTH=4, RESET_PC=0, HALT_ZEROS=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [2:0]  count;
    logic        halt;

    // 0: word[n] = n+1
    // 1: words at 0x8..0x18 are zero
    // 2: words at 0x8..0x14 and 0x1C are zero (0x18 nonzero)
    int          mode;

    int          n_checks;
    int          n_fail;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .count       (count),
        .halt        (halt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int m);
        logic z;
        z = 1'b0;
        if (m == 1 && a >= 32'h8 && a <= 32'h18) z = 1'b1;
        if (m == 2 && ((a >= 32'h8 && a <= 32'h14) || a == 32'h1C)) z = 1'b1;
        return z ? 32'd0 : ((a >> 2) + 32'd1);
    endfunction

    always_comb begin
        imem_data = mem_word(imem_addr, mode);
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous pulse strictly between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mode        = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;

        // ---------------- streaming ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            check("str_pc", 64'(out_pc), 64'(4 * i));
            check("str_inst", 64'(out_inst), 64'(i + 1));
            check("str_pc4", 64'(out_pc4), 64'(4 * i + 4));
            check("str_count", 64'(count), 64'd1);
            check("str_valid", 64'(out_valid), 64'd1);
        end

        // ---------------- backpressure / full ----------------
        out_ready = 1'b0;
        pulse_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("bp_count", 64'(count), 64'((i < 4) ? i : 4));
            check("bp_head", 64'(out_pc), 64'd0);
        end
        check("bp_addr", 64'(imem_addr), 64'h10);
        check("bp_inst", 64'(out_inst), 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("rel_pc", 64'(out_pc), 64'(4 * i));
            check("rel_inst", 64'(out_inst), 64'(i + 1));
            check("rel_count", 64'(count), 64'd4);
        end

        // ---------------- redirect ----------------
        redirect    = 1'b1;
        redirect_pc = 32'h123;
        tick();
        check("rd_count", 64'(count), 64'd0);
        check("rd_valid", 64'(out_valid), 64'd0);
        check("rd_addr", 64'(imem_addr), 64'h120);
        redirect = 1'b0;
        tick();
        check("rd_pc", 64'(out_pc), 64'h120);
        check("rd_inst", 64'(out_inst), 64'h49);
        check("rd_count1", 64'(count), 64'd1);

        // ---------------- async reset mid-operation ----------------
        out_ready = 1'b0;
        pulse_reset();
        repeat (3) tick();
        check("ar_pre_count", 64'(count), 64'd3);
        reset = 1'b1;
        #1;
        check("ar_count", 64'(count), 64'd0);
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_addr", 64'(imem_addr), 64'd0);
        check("ar_halt", 64'(halt), 64'd0);
        reset = 1'b0;

        // ---------------- halt ----------------
        mode      = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("h_pc", 64'(out_pc), 64'(4 * i));
            check("h_inst", 64'(out_inst), 64'((i < 2) ? i + 1 : 0));
            check("h_halt", 64'(halt), 64'((i == 6) ? 1 : 0));
        end
        check("h_addr", 64'(imem_addr), 64'h1C);
        check("h_count", 64'(count), 64'd1);
        tick();
        check("h_drain_count", 64'(count), 64'd0);
        check("h_drain_valid", 64'(out_valid), 64'd0);
        check("h_frozen_addr", 64'(imem_addr), 64'h1C);
        check("h_sticky", 64'(halt), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("hr_halt", 64'(halt), 64'd1);
        check("hr_addr", 64'(imem_addr), 64'h40);
        check("hr_count", 64'(count), 64'd0);
        redirect = 1'b0;
        tick();
        check("hr_nofetch_count", 64'(count), 64'd0);
        check("hr_nofetch_addr", 64'(imem_addr), 64'h40);
        check("hr_halt2", 64'(halt), 64'd1);

        // ---------------- zero run broken by nonzero word ----------------
        mode = 2;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("zc_pc", 64'(out_pc), 64'(4 * i));
            check("zc_halt", 64'(halt), 64'd0);
        end
        check("zc_addr", 64'(imem_addr), 64'h28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
